// File: rtl/burst_ram_arbiter_if.sv
// burst_ram_arbiter_if: one requester's burst channel (request, write-beat and read-beat handshake)
interface burst_ram_arbiter_if #(
    parameter int ADDR_BITWIDTH = 4,
    parameter int DATA_BITWIDTH = 64
);
    logic                     req;
    logic                     cmd;
    logic [ADDR_BITWIDTH-1:0] addr;
    logic [DATA_BITWIDTH-1:0] wr_data;
    logic                     wr_next;
    logic [DATA_BITWIDTH-1:0] rd_data;
    logic                     rd_data_valid;
    logic                     done;
    modport master (output req, cmd, addr, wr_data, input wr_next, rd_data, rd_data_valid, done);
    modport slave (input req, cmd, addr, wr_data, output wr_next, rd_data, rd_data_valid, done);
endinterface

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: round-robin sharing of one burst RAM port between two requesters
module burst_ram_arbiter #(
    parameter int ADDR_BITWIDTH = 4,
    parameter int DATA_BITWIDTH = 64,
    parameter int BURST_COUNT   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    burst_ram_arbiter_if.slave         p0,
    burst_ram_arbiter_if.slave         p1,
    output logic                       ram_cmd,
    output logic                       ram_cmd_en,
    output logic [ADDR_BITWIDTH-1:0]   ram_addr,
    output logic [DATA_BITWIDTH-1:0]   ram_wr_data,
    output logic [DATA_BITWIDTH/8-1:0] ram_data_mask,
    input  logic [DATA_BITWIDTH-1:0]   ram_rd_data,
    input  logic                       ram_rd_data_valid,
    input  logic                       ram_busy
);
    localparam int BW = $clog2(BURST_COUNT);
    typedef enum logic [1:0] {IDLE, ISSUE, WBEAT, WAIT} state_t;
    state_t                   state_q, state_d;
    logic                     owner_q, owner_d, last_q, last_d;
    logic                     cmd_en_q, cmd_en_d, cmd_q, cmd_d;
    logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
    logic [1:0]               done_q, done_d, elig;
    logic [BW-1:0]            beat_q, beat_d;
    logic                     pick, wr_phase, rd_phase;
    // a port pulsing done is ineligible so a registered requester can drop req one edge later
    assign elig = {p1.req & ~done_q[1], p0.req & ~done_q[0]};
    assign pick = &elig ? ~last_q : elig[1];
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cmd_en_d = 1'b0;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        done_d   = 2'b00;
        beat_d   = beat_q;
        case (state_q)
            IDLE: if (|elig && !ram_busy) begin
                state_d  = ISSUE;
                owner_d  = pick;
                cmd_en_d = 1'b1;
                cmd_d    = pick ? p1.cmd : p0.cmd;
                addr_d   = pick ? p1.addr : p0.addr;
            end
            ISSUE: begin
                last_d  = owner_q;
                beat_d  = BW'(1);
                state_d = cmd_q ? WBEAT : WAIT;
            end
            WBEAT: begin
                beat_d  = beat_q + 1'b1;
                state_d = (beat_q == BW'(BURST_COUNT - 1)) ? WAIT : WBEAT;
            end
            WAIT: if (!ram_busy) begin
                state_d = IDLE;
                done_d  = owner_q ? 2'b10 : 2'b01;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cmd_en_q <= 1'b0;
            cmd_q    <= 1'b0;
            addr_q   <= '0;
            done_q   <= 2'b00;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cmd_en_q <= cmd_en_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            beat_q   <= beat_d;
        end
    end
    // write beat 0 rides on the cmd_en cycle, the rest follow back to back
    assign wr_phase = (state_q == ISSUE && cmd_q) || state_q == WBEAT;
    assign rd_phase = state_q == WAIT && ram_rd_data_valid;
    assign p0.wr_next       = wr_phase & ~owner_q;
    assign p1.wr_next       = wr_phase & owner_q;
    assign p0.rd_data_valid = rd_phase & ~owner_q;
    assign p1.rd_data_valid = rd_phase & owner_q;
    assign p0.done          = done_q[0];
    assign p1.done          = done_q[1];
    assign p0.rd_data       = ram_rd_data;
    assign p1.rd_data       = ram_rd_data;
    assign ram_cmd          = cmd_q;
    assign ram_cmd_en       = cmd_en_q;
    assign ram_addr         = addr_q;
    assign ram_wr_data      = owner_q ? p1.wr_data : p0.wr_data;
    assign ram_data_mask    = '0;
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// tb_burst_ram_arbiter: directed and random bursts from two requesters against a burst RAM model
module tb_burst_ram_arbiter;
    localparam int AW = 4, DW = 64, BC = 4, LAT = 3;
    logic clk = 1'b0, rst_n;
    always #5 clk = ~clk;

    logic [1:0]    req, cmd_v;
    logic [AW-1:0] addr_v [2];
    logic [DW-1:0] wr_v [2];
    logic          force_busy, abort;
    logic [1:0]    drv_active;

    logic          ram_cmd, ram_cmd_en, ram_rd_data_valid, ram_busy, r_busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data, ram_rd_data;
    logic [DW/8-1:0] ram_data_mask;
    logic [1:0]    wn, rv, dn;
    logic [DW-1:0] rdd [2];

    burst_ram_arbiter_if #(.ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW)) p0_if ();
    burst_ram_arbiter_if #(.ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW)) p1_if ();
    assign p0_if.req = req[0];
    assign p0_if.cmd = cmd_v[0];
    assign p0_if.addr = addr_v[0];
    assign p0_if.wr_data = wr_v[0];
    assign p1_if.req = req[1];
    assign p1_if.cmd = cmd_v[1];
    assign p1_if.addr = addr_v[1];
    assign p1_if.wr_data = wr_v[1];
    assign wn = {p1_if.wr_next, p0_if.wr_next};
    assign rv = {p1_if.rd_data_valid, p0_if.rd_data_valid};
    assign dn = {p1_if.done, p0_if.done};
    assign rdd[0] = p0_if.rd_data;
    assign rdd[1] = p1_if.rd_data;
    assign ram_busy = r_busy | force_busy;

    burst_ram_arbiter #(.ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW), .BURST_COUNT(BC)) dut (
        .clk(clk), .rst_n(rst_n), .p0(p0_if), .p1(p1_if),
        .ram_cmd(ram_cmd), .ram_cmd_en(ram_cmd_en), .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data), .ram_data_mask(ram_data_mask),
        .ram_rd_data(ram_rd_data), .ram_rd_data_valid(ram_rd_data_valid), .ram_busy(ram_busy));

    // Burst RAM: busy from the edge after cmd_en, write beats on consecutive edges, reads after LAT
    logic [DW-1:0] mem [16];
    logic r_on, r_cmd;
    int   r_t, r_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_on <= 1'b0; r_busy <= 1'b0; r_t <= 0; r_cmd <= 1'b0; r_addr <= 0;
            ram_rd_data_valid <= 1'b0; ram_rd_data <= '0;
        end else if (!r_on) begin
            ram_rd_data_valid <= 1'b0;
            if (ram_cmd_en) begin
                r_on <= 1'b1; r_busy <= 1'b1; r_t <= 1; r_cmd <= ram_cmd; r_addr <= int'(ram_addr);
                if (ram_cmd) mem[ram_addr] <= ram_wr_data;
            end
        end else begin
            r_t <= r_t + 1;
            if (r_cmd) begin
                if (r_t < BC) mem[(r_addr + r_t) % 16] <= ram_wr_data;
                if (r_t == BC + 1) begin r_on <= 1'b0; r_busy <= 1'b0; end
            end else begin
                ram_rd_data_valid <= r_t >= LAT && r_t < LAT + BC;
                ram_rd_data <= mem[(r_addr + r_t + 16 - LAT) % 16];
                if (r_t == LAT + BC) begin r_on <= 1'b0; r_busy <= 1'b0; end
            end
        end
    end

    // Reference model: a burst is an interval measured in cycles from its cmd_en
    logic       m_act, m_own, m_last, m_cmd, m_pick, m_wait, e_cmd_en;
    logic [AW-1:0] m_addr;
    logic [1:0] m_done, m_elig, e_wn, e_rv;
    int         m_age;
    always_comb begin
        m_elig   = req & ~m_done;
        m_pick   = (m_elig == 2'b11) ? ~m_last : m_elig[1];
        m_wait   = m_age >= (m_cmd ? BC : 1);
        e_cmd_en = m_act && m_age == 0;
        e_wn     = (m_act && m_cmd && m_age < BC) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
        e_rv     = (m_act && m_wait && ram_rd_data_valid) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0; m_own <= 1'b0; m_last <= 1'b1; m_cmd <= 1'b0;
            m_addr <= '0; m_age <= 0; m_done <= 2'b00;
        end else begin
            m_done <= (m_act && m_wait && !ram_busy) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
            if (!m_act && m_elig != 2'b00 && !ram_busy) begin
                m_act <= 1'b1; m_own <= m_pick; m_last <= m_pick;
                m_cmd <= cmd_v[m_pick]; m_addr <= addr_v[m_pick]; m_age <= 0;
            end else if (m_act) begin
                m_age <= m_age + 1;
                if (m_wait && !ram_busy) m_act <= 1'b0;
            end
        end
    end

    int n_tests = 0, n_fail = 0, n_cmd_en = 0;
    int done_log [$];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] rd_got [2][BC];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("cmd_en", ram_cmd_en, e_cmd_en);
            chk("ram_cmd", ram_cmd, m_cmd);
            chk("ram_addr", ram_addr, m_addr);
            chk("wr_next", wn, e_wn);
            chk("rd_valid", rv, e_rv);
            chk("done", dn, m_done);
            chk("mask", ram_data_mask, 0);
            chk("rd_data0", rdd[0], ram_rd_data);
            chk("rd_data1", rdd[1], ram_rd_data);
            if (m_act && m_cmd && m_age < BC) chk("wr_data", ram_wr_data, wr_v[m_own]);
            if (ram_cmd_en) n_cmd_en++;
            if (dn[0]) done_log.push_back(0);
            if (dn[1]) done_log.push_back(1);
        end
    endtask

    task automatic do_burst(input int p, input logic c, input logic [AW-1:0] a,
                            input logic [DW-1:0] base, input logic [DW-1:0] step);
        int nw = 0, nr = 0, g = 0;
        logic nx, fin = 1'b0;
        drv_active[p] = 1'b1;
        @(negedge clk);
        req[p] = 1'b1; cmd_v[p] = c; addr_v[p] = a; wr_v[p] = base;
        while (!fin && !abort && g < 300) begin
            @(negedge clk);
            g++;
            nx = wn[p];
            fin = dn[p];
            if (rv[p]) begin
                if (nr < BC) rd_got[p][nr] = rdd[p];
                chk("rd_beat", rdd[p], ref_mem[(a + nr) % 16]);
                nr++;
            end
            @(posedge clk);
            #1;
            if (nx) begin nw++; wr_v[p] = base + step * nw; end
        end
        req[p] = 1'b0;
        drv_active[p] = 1'b0;
        if (abort) return;
        chk("burst_timeout", g < 300, 1);
        if (c) begin
            chk("wr_beats", nw, BC);
            for (int i = 0; i < BC; i++) begin
                ref_mem[(a + i) % 16] = base + step * i;
                chk("ram_content", mem[(a + i) % 16], base + step * i);
            end
        end else chk("rd_beats", nr, BC);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, g, n0;
        int exp_ord [4] = '{0, 1, 0, 1};
        req = '0; cmd_v = '0; addr_v[0] = '0; addr_v[1] = '0; wr_v[0] = '0; wr_v[1] = '0;
        force_busy = 1'b0; abort = 1'b0; drv_active = '0; rst_n = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        fork compare_loop(); join_none
        repeat (2) @(negedge clk);
        chk("reset cmd_en", ram_cmd_en, 0);
        chk("reset ram_cmd", ram_cmd, 0);
        chk("reset ram_addr", ram_addr, 0);
        chk("reset wr_next", wn, 0);
        chk("reset done", dn, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) do_burst(i % 2, 1'b1, 4'(i * 4), {$urandom, $urandom}, 64'd3);
        do_burst(1, 1'b1, 4'd8, 64'hA0, 64'd1);
        for (int i = 0; i < BC; i++) chk("t2 ram", mem[8 + i], 64'hA0 + 64'(i));
        do_burst(0, 1'b1, 4'd2, 64'h11, 64'h11);
        do_burst(0, 1'b0, 4'd2, '0, '0);
        for (int i = 0; i < BC; i++) chk("t1 rd", rd_got[0][i], 64'h11 * 64'(i + 1));
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        base = done_log.size();
        fork
            begin repeat (2) do_burst(0, 1'b0, 4'($urandom_range(0, 15)), '0, '0); end
            begin repeat (2) do_burst(1, 1'b1, 4'($urandom_range(0, 15)), {$urandom, $urandom}, 64'd1); end
        join
        chk("t3 dones", done_log.size() - base, 4);
        for (int k = 0; k < 4; k++) if (base + k < done_log.size()) chk("t3 order", done_log[base + k], exp_ord[k]);
        n0 = n_cmd_en;
        do_burst(0, 1'b0, 4'd6, '0, '0);
        repeat (10) @(negedge clk);
        chk("t4 bursts", n_cmd_en - n0, 1);
        force_busy = 1'b1;
        n0 = n_cmd_en;
        fork do_burst(0, 1'b0, 4'd1, '0, '0); join_none
        repeat (6) @(negedge clk);
        chk("t5 held", n_cmd_en - n0, 0);
        force_busy = 1'b0;
        @(negedge clk);
        chk("t5 issue", ram_cmd_en, 1);
        g = 0;
        while (drv_active != 0 && g < 400) begin @(negedge clk); g++; end
        for (int it = 0; it < 25; it++) begin
            fork
                begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_burst(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom}, 64'($urandom_range(1, 9)));
                end
                begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    do_burst(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom}, 64'($urandom_range(1, 9)));
                end
            join
        end
        fork do_burst(1, 1'b1, 4'd12, 64'hB0, 64'd1); join_none
        g = 0;
        while (!ram_cmd_en && g < 50) begin @(negedge clk); g++; end
        chk("t6 grant", g < 50, 1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("t6 cmd_en", ram_cmd_en, 0);
        chk("t6 wr_next", wn, 0);
        chk("t6 done", dn, 0);
        g = 0;
        while (drv_active != 0 && g < 20) begin @(negedge clk); g++; end
        abort = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        do_burst(1, 1'b0, 4'd4, '0, '0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
